pipe_stage_reg: RTL

- Parametrised, elastic pipeline register that replaces fixed-width, enable-only stage registers such as the IF/ID register.
- Carries an opaque WIDTH-bit payload (e.g. instr|pc|pc4 packed) between two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is driven directly from a flop and no ready path is combinational.
- Adds synchronous flush (branch/exception kill) and zero-payload bubbles. One instance is placed per stage boundary (IF/ID, ID/EX, ...).

---
 rtl/pipe_pkg.sv | 50 +++++
 rtl/pipe_perf_counter.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the elastic pipeline stage registers.
//   pipe_state_t     : occupancy of a stage register (EMPTY / ONE / TWO beats)
//   PIPE_PERF_W      : width of the optional performance counters
//   if_id_payload_t  : packed IF/ID boundary payload {instr, pc, pc4}
//   id_ex_payload_t  : packed ID/EX boundary payload
//   pipe_state()     : occupancy derived from the main/skid valid bits
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_ONE,
        PS_TWO
    } pipe_state_t;

    localparam int unsigned PIPE_PERF_W = 32;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_id_payload_t;

    localparam int unsigned IF_ID_W = $bits(if_id_payload_t);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
    } id_ex_payload_t;

    localparam int unsigned ID_EX_W = $bits(id_ex_payload_t);

    // A skid entry without a main entry never occurs; it is folded into TWO
    // here and caught by the assertion in the stage register.
    function automatic pipe_state_t pipe_state(input logic main_v, input logic skid_v);
        if (!main_v && !skid_v) begin
            return PS_EMPTY;
        end else if (!skid_v) begin
            return PS_ONE;
        end else begin
            return PS_TWO;
        end
    endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// -----------------------------------------------------------------------------
// pipe_perf_counter
// Saturating event counter; adds inc_i every cycle and sticks at all-ones.
//   clk     : clock
//   reset   : asynchronous, active-high reset (count returns to 0)
//   inc_i   : amount to add this cycle
//   count_o : current count
// -----------------------------------------------------------------------------
module pipe_perf_counter
    import pipe_pkg::*;
#(
    parameter int unsigned W     = PIPE_PERF_W,
    parameter int unsigned INC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] inc_i,
    output logic [W-1:0]     count_o
);

    logic [W:0]   sum;
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: combinational blocks assign every output up front, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        sum     = {1'b0, count_q} + {{(W + 1 - INC_W){1'b0}}, inc_i};
        count_d = sum[W] ? '1 : sum[W-1:0];
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic valid/ready pipeline register with a 2-entry skid buffer, one per
// stage boundary. in_ready comes straight from a flop, so no ready path is
// combinational. Flush kills held and incoming beats at the next edge.
// Optional feature macro: PIPE_STAGE_PERF_EN (adds stall_cnt / flush_cnt).
//   clk       : clock
//   reset     : asynchronous, active-high reset
//   flush     : synchronous kill of all held and incoming beats
//   in_valid  : upstream beat valid
//   in_ready  : stage can accept a beat (registered)
//   in_data   : upstream payload
//   out_valid : downstream beat valid
//   out_ready : downstream accepts
//   out_data  : downstream payload ('0 during bubbles when BUBBLE_ZERO=1)
//   stall_cnt : cycles with out_valid & !out_ready   (PIPE_STAGE_PERF_EN)
//   flush_cnt : valid beats discarded by flush       (PIPE_STAGE_PERF_EN)
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH       = 96,
    parameter bit          BUBBLE_ZERO = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PIPE_PERF_W-1:0] stall_cnt,
    output logic [PIPE_PERF_W-1:0] flush_cnt
`endif
);

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_ready_q, in_ready_d;

    pipe_state_t      state;
    logic             in_fire;
    logic             out_fire;

    assign state    = pipe_state(main_v_q, skid_v_q);
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_v_q & out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Data registers are left alone; only the beats are killed.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (in_fire) begin
                        main_v_d    = 1'b1;
                        main_data_d = in_data;
                    end
                end
                PS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        skid_v_d    = 1'b1;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        main_v_d = 1'b0;
                    end
                end
                PS_TWO: begin
                    // in_ready is low here, so only the drain case exists.
                    if (out_fire) begin
                        skid_v_d    = 1'b0;
                        main_data_d = skid_data_q;
                    end
                end
                default: ;
            endcase
        end

        // Registered copy of !skid_v so in_ready leaves the block from a flop.
        in_ready_d = ~skid_v_d;
    end

    // NOTE: the payload registers are reset along with the valid bits so that
    // out_data is a defined '0 after reset even with BUBBLE_ZERO=0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_data_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;

    generate
        if (BUBBLE_ZERO) begin : g_bubble_zero
            assign out_data = main_v_q ? main_data_q : '0;
        end else begin : g_bubble_raw
            assign out_data = main_data_q;
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    logic [1:0] stall_inc;
    logic [1:0] flush_inc;

    assign stall_inc = {1'b0, main_v_q & ~out_ready};
    assign flush_inc = flush ? ({1'b0, main_v_q} + {1'b0, skid_v_q} + {1'b0, in_fire}) : 2'd0;

    pipe_perf_counter #(
        .W     (PIPE_PERF_W),
        .INC_W (2)
    ) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (stall_inc),
        .count_o (stall_cnt)
    );

    pipe_perf_counter #(
        .W     (PIPE_PERF_W),
        .INC_W (2)
    ) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (flush_inc),
        .count_o (flush_cnt)
    );
`else
    // Performance counters are not built; the stage behaves identically.
`endif

    a_no_orphan_skid: assert property (@(posedge clk) disable iff (reset)
        !(skid_v_q && !main_v_q));

    a_ready_tracks_skid: assert property (@(posedge clk) disable iff (reset)
        in_ready_q == ~skid_v_q);

endmodule
